// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, buffers responses in a
// 2-entry FIFO and hands them to the decoder with a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_mem_q [2];
  logic [31:0] pc_mem_d [2];
  logic [31:0] inst_mem_q [2];
  logic [31:0] inst_mem_d [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q, inflight_d;
  logic        stale_q, stale_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic        tail;
  logic [2:0]  occupancy;
  logic        unused_lo;

  // Redirect targets are word aligned; the low bits carry no meaning.
  assign unused_lo = ^redirect_pc[1:0];

  // Handshake, issue decision and FIFO head outputs.
  always_comb begin
    inst_valid = (count_q != 2'd0);
    inst_out   = inst_mem_q[head_q];
    pc_out     = pc_mem_q[head_q];
    pop        = inst_valid & inst_ready;
    push       = inflight_q & ~stale_q;
    occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
    issue      = ~reset & ~redirect_valid
               & ((occupancy < 3'd2) | pop);
    tail       = head_q ^ count_q[0];
    mem_addr   = fetch_pc_q;
    mem_en     = issue;
  end

  // Next-state: redirect flushes everything, otherwise push/pop/issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pc_mem_d      = pc_mem_q;
    inst_mem_d    = inst_mem_q;
    head_d        = head_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    stale_d       = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
      stale_d    = inflight_q;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        pc_mem_d[tail]   = inflight_pc_q;
        inst_mem_d[tail] = mem_rdata;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      pc_mem_q[0]   <= '0;
      pc_mem_q[1]   <= '0;
      inst_mem_q[0] <= '0;
      inst_mem_q[1] <= '0;
      head_q        <= 1'b0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      stale_q       <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pc_mem_q      <= pc_mem_d;
      inst_mem_q    <= inst_mem_d;
      head_q        <= head_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      stale_q       <= stale_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected pcs, memory returns
// address ^ KEY one cycle after the address is presented.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr, mem_addr2;
  logic        mem_en, mem_en2;
  logic [31:0] mem_rdata, mem_rdata2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_valid2;
  logic        inst_ready;
  logic [31:0] inst_out, inst_out2;
  logic [31:0] pc_out, pc_out2;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  logic        s_valid, s_mem_en, s2_valid, s2_mem_en;
  logic [31:0] s_pc, s_inst, s_addr, s2_pc, s2_inst, s2_addr;

  fetch_unit u_dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .pc_out(pc_out)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr2), .mem_en(mem_en2), .mem_rdata(mem_rdata2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid2), .inst_ready(inst_ready),
    .inst_out(inst_out2), .pc_out(pc_out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory with one cycle read latency.
  always @(posedge clk) begin
    mem_rdata  <= mem_addr ^ KEY;
    mem_rdata2 <= mem_addr2 ^ KEY;
  end

  // Advance one cycle: snapshot outputs mid-cycle, retire any pop
  // against the scoreboard, then return just after the rising edge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    s_valid   = inst_valid;
    s_pc      = pc_out;
    s_inst    = inst_out;
    s_mem_en  = mem_en;
    s_addr    = mem_addr;
    s2_valid  = inst_valid2;
    s2_pc     = pc_out2;
    s2_inst   = inst_out2;
    s2_mem_en = mem_en2;
    s2_addr   = mem_addr2;
    if (inst_valid && inst_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got pc=%h, expected no output", pc_out);
      end else begin
        e = exp_q.pop_front();
        if (pc_out !== e || inst_out !== (e ^ KEY)) begin
          n_err++;
          $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h",
                   pc_out, inst_out, e, e ^ KEY);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0500;
    step();
    step();
    n_vec++;
    if (s_mem_en !== 1'b0 || s2_mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mem_en: got %b/%b, expected 0/0", s_mem_en, s2_mem_en);
    end
    n_vec++;
    if (s_valid !== 1'b0 || s_pc !== 32'h0 || s_inst !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b pc=%h inst=%h, expected 0/0/0",
               s_valid, s_pc, s_inst);
    end
    n_vec++;
    if (s_addr !== 32'h0 || s2_addr !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL reset_pc: got %h/%h, expected 00000000/fffffff8",
               s_addr, s2_addr);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b0;
    inst_ready = 1'b1;
    step();
    n_vec++;
    if (s_mem_en !== 1'b1 || s_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_issue: got en=%b addr=%h, expected 1/00000000",
               s_mem_en, s_addr);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL cycle1_valid: got %b, expected 0", s_valid);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 32'h0) begin
      n_err++;
      $display("FAIL cycle2_valid: got v=%b pc=%h, expected 1/00000000",
               s_valid, s_pc);
    end
    for (int i = 0; i < 9; i++) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(40 + i * 4));
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (s_valid !== 1'b1 || s_pc !== 32'd40 || s_inst !== (32'd40 ^ KEY)
          || s_mem_en !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold: got v=%b pc=%h inst=%h en=%b, expected 1/%h/%h/0",
                 s_valid, s_pc, s_inst, s_mem_en, 32'd40, 32'd40 ^ KEY);
      end
    end
    inst_ready = 1'b1;
    step();
    n_vec++;
    if (s_mem_en !== 1'b1 || s_addr !== 32'd48) begin
      n_err++;
      $display("FAIL stall_release_issue: got en=%b addr=%h, expected 1/%h",
               s_mem_en, s_addr, 32'd48);
    end
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_redirect();
    exp_q.push_back(32'd60);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    n_vec++;
    if (s_mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_no_issue: got %b, expected 0", s_mem_en);
    end
    redirect_valid = 1'b0;
    step();
    n_vec++;
    if (s_mem_en !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_n1: got en=%b addr=%h v=%b, expected 1/00000100/0",
               s_mem_en, s_addr, s_valid);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redirect_n2: got v=%b, expected 0", s_valid);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 32'h100) begin
      n_err++;
      $display("FAIL redirect_n3: got v=%b pc=%h, expected 1/00000100",
               s_valid, s_pc);
    end
    step();
    step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL redirect_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_full();
    inst_ready = 1'b0;
    step();
    step();
    n_vec++;
    if (s_valid !== 1'b1 || s_pc !== 32'h10C || s_mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL full_state: got v=%b pc=%h en=%b, expected 1/0000010c/0",
               s_valid, s_pc, s_mem_en);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (s_mem_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gate_en: got %b, expected 0", s_mem_en);
    end
    step();
    n_vec++;
    if (s_valid !== 1'b0 || s_mem_en !== 1'b0 || s_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_flush: got v=%b en=%b pc=%h, expected 0/0/00000000",
               s_valid, s_mem_en, s_pc);
    end
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b0;
    inst_ready = 1'b1;
    step();
    n_vec++;
    if (s_mem_en !== 1'b1 || s_addr !== 32'h0) begin
      n_err++;
      $display("FAIL restart_issue: got en=%b addr=%h, expected 1/00000000",
               s_mem_en, s_addr);
    end
    for (int i = 0; i < 4; i++) step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL restart_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    inst_ready = 1'b0;
    reset = 1'b1;
    step();
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    reset = 1'b0;
    inst_ready = 1'b1;
    step();
    n_vec++;
    if (s2_mem_en !== 1'b1 || s2_addr !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_issue: got en=%b addr=%h, expected 1/fffffff8",
               s2_mem_en, s2_addr);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (s2_valid !== 1'b1 || s2_pc !== wexp[i] || s2_inst !== (wexp[i] ^ KEY)) begin
        n_err++;
        $display("FAIL wrap_seq%0d: got v=%b pc=%h inst=%h, expected 1/%h/%h",
                 i, s2_valid, s2_pc, s2_inst, wexp[i], wexp[i] ^ KEY);
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_full();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
